// File: rtl/enc32_pkg.sv
// Shared definitions for the 32-to-5 serial encoder (serial_encoder32)
// and its lowest-set-bit encoder (lsb_encoder32).
package enc32_pkg;

  localparam int WIDTH  = 32;
  localparam int IDXW   = 5;
  localparam int COUNTW = 6;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Number of set bits in a request mask; 32 fits in COUNTW bits.
  function automatic logic [COUNTW-1:0] popcount32(input logic [WIDTH-1:0] v);
    logic [COUNTW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{(COUNTW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lsb_encoder32.sv
// Combinational 32-bit lowest-set-bit encoder built from gate primitives.
// Produces the index of the lowest set bit (0 when the vector is empty),
// an any-set flag and a flag for exactly one bit set.
module lsb_encoder32
  import enc32_pkg::*;
(
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDXW-1:0]  o_index,
  output logic             o_any,
  output logic             o_single
);

  // w_pre[k]   : any of bits 0..k set
  // w_multi[k] : two or more of bits 0..k set
  // w_iso[k]   : bit k is the lowest set bit
  wire [WIDTH-1:0]            w_pre;
  wire [WIDTH-1:0]            w_multi;
  wire [WIDTH-2:0]            w_npre;
  wire [WIDTH-1:1]            w_iso;
  wire [WIDTH-1:1]            w_dup;
  wire [IDXW-1:0][WIDTH-1:1]  w_ch;
  wire                        w_nmulti;

  buf g_pre0 (w_pre[0], i_vec[0]);
  assign w_multi[0] = 1'b0;

  // Prefix OR, lowest-bit isolation and duplicate detection chains.
  for (genvar k = 1; k < WIDTH; k++) begin : g_bit
    or  g_pre   (w_pre[k], w_pre[k-1], i_vec[k]);
    not g_npre  (w_npre[k-1], w_pre[k-1]);
    and g_iso   (w_iso[k], i_vec[k], w_npre[k-1]);
    and g_dup   (w_dup[k], i_vec[k], w_pre[k-1]);
    or  g_multi (w_multi[k], w_multi[k-1], w_dup[k]);
  end

  // Each index bit ORs the isolated one-hot lines whose position has that bit set.
  for (genvar b = 0; b < IDXW; b++) begin : g_idx
    for (genvar k = 1; k < WIDTH; k++) begin : g_term
      if (k == 1) begin : g_first
        if (((k >> b) & 1) == 1) begin : g_use
          buf g_b (w_ch[b][k], w_iso[k]);
        end else begin : g_skip
          assign w_ch[b][k] = 1'b0;
        end
      end else begin : g_rest
        if (((k >> b) & 1) == 1) begin : g_use
          or  g_o (w_ch[b][k], w_ch[b][k-1], w_iso[k]);
        end else begin : g_skip
          buf g_b (w_ch[b][k], w_ch[b][k-1]);
        end
      end
    end
    buf g_out (o_index[b], w_ch[b][WIDTH-1]);
  end

  buf g_any    (o_any, w_pre[WIDTH-1]);
  not g_nmulti (w_nmulti, w_multi[WIDTH-1]);
  and g_single (o_single, w_pre[WIDTH-1], w_nmulti);

endmodule

// File: rtl/serial_encoder32.sv
// Sequential 32-to-5 encoder: captures a multi-hot mask and emits the
// indices of its set bits lowest first over a valid/ready handshake.
// Optional macro SERIAL_ENCODER32_COUNT_EN adds out_count, the population
// count of the captured mask, held for the whole emission.
//
//   state | meaning
//   IDLE  | waiting for a mask (in_ready high once out of reset)
//   EMIT  | streaming indices of the remaining set bits in r_pend
module serial_encoder32 #(
  parameter int WIDTH = enc32_pkg::WIDTH,
  parameter int IDXW  = enc32_pkg::IDXW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             busy
`ifdef SERIAL_ENCODER32_COUNT_EN
  ,
  output logic [enc32_pkg::COUNTW-1:0] out_count
`endif
);

  import enc32_pkg::*;

  state_t           r_state;
  logic [WIDTH-1:0] r_pend;
  logic             r_in_ready;
`ifdef SERIAL_ENCODER32_COUNT_EN
  logic [COUNTW-1:0] r_count;
`endif

  logic [IDXW-1:0]  w_index;
  logic             w_any;
  logic             w_single;
  logic             w_valid;
  logic [WIDTH-1:0] w_onehot;
  logic [WIDTH-1:0] w_pend_clr;
  logic             w_capture;
  logic             w_done;

  lsb_encoder32 u_lsb (
    .i_vec    (r_pend),
    .o_index  (w_index),
    .o_any    (w_any),
    .o_single (w_single)
  );

  assign w_valid    = (r_state == EMIT) && w_any;
  assign w_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << w_index;
  assign w_pend_clr = r_pend & ~w_onehot;
  assign w_capture  = (r_state == IDLE) && r_in_ready && in_valid;
  assign w_done     = w_valid && out_ready && w_single;

  // in_ready is held low through reset so no capture can race the release.
  // FSM, pend register and optional count; all outputs decode these registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_in_ready <= 1'b0;
`ifdef SERIAL_ENCODER32_COUNT_EN
      r_count    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_capture) begin
`ifdef SERIAL_ENCODER32_COUNT_EN
            r_count <= popcount32(in_mask);
`endif
            if (in_mask != '0) begin
              r_pend     <= in_mask;
              r_state    <= EMIT;
              r_in_ready <= 1'b0;
            end
          end
        end
        EMIT: begin
          r_in_ready <= 1'b0;
          if (w_valid && out_ready) begin
            r_pend <= w_pend_clr;
          end
          if (w_done) begin
            r_pend     <= '0;
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
`ifdef SERIAL_ENCODER32_COUNT_EN
            r_count    <= '0;
`endif
          end
        end
        default: begin
          r_state    <= IDLE;
          r_pend     <= '0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_valid;
  assign out_index = w_valid ? w_index : '0;
  assign out_last  = w_valid && w_single;
  assign busy      = (r_state == EMIT);
`ifdef SERIAL_ENCODER32_COUNT_EN
  assign out_count = r_count;
`endif

endmodule

// File: tb/tb_serial_encoder32.sv
// Self-checking bench for serial_encoder32. Works with or without
// SERIAL_ENCODER32_COUNT_EN defined.
module tb_serial_encoder32;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
`ifdef SERIAL_ENCODER32_COUNT_EN
  logic [5:0]  out_count;
`endif

  int n_vec;
  int n_err;

  serial_encoder32 dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
`ifdef SERIAL_ENCODER32_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // mode: 0 = always ready, 1 = ready toggles 1,0,1,0..., 2 = random stalls.
  // hold_next keeps in_valid high with an all-ones mask during emission.
  // Returns the number of handshakes seen.
  task automatic send_mask(input logic [31:0] m, input int mode,
                           input bit hold_next, output int n_hs);
    int exp_q[$];
    int cyc;
    int pop;
    bit tog;
    n_hs = 0;
    pop  = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        exp_q.push_back(i);
        pop++;
      end
    end
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("ready_before_capture", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_mask  = m;
    tick();
    if (hold_next) in_mask = 32'hFFFF_FFFF;
    else           in_valid = 1'b0;
    if (exp_q.size() == 0) begin
      chk("zero_no_valid", {31'b0, out_valid}, 32'd0);
      chk("zero_ready", {31'b0, in_ready}, 32'd1);
      chk("zero_busy", {31'b0, busy}, 32'd0);
`ifdef SERIAL_ENCODER32_COUNT_EN
      chk("zero_count", {26'b0, out_count}, 32'd0);
`endif
      return;
    end
    cyc = 0;
    tog = 1'b1;
    while (exp_q.size() > 0 && cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = tog;
        default: out_ready = ($urandom_range(99) >= 40);
      endcase
      tog = ~tog;
      chk("emit_valid", {31'b0, out_valid}, 32'd1);
      chk("emit_index", {27'b0, out_index}, exp_q[0]);
      chk("emit_last", {31'b0, out_last}, {31'b0, (exp_q.size() == 1)});
      chk("emit_no_ready", {31'b0, in_ready}, 32'd0);
`ifdef SERIAL_ENCODER32_COUNT_EN
      chk("emit_count", {26'b0, out_count}, pop);
`endif
      tick();
      if (out_ready) begin
        void'(exp_q.pop_front());
        n_hs++;
      end
      cyc++;
    end
    out_ready = 1'b0;
    chk("emit_drained", exp_q.size(), 32'd0);
    chk("after_valid", {31'b0, out_valid}, 32'd0);
    chk("after_ready", {31'b0, in_ready}, 32'd1);
    chk("after_busy", {31'b0, busy}, 32'd0);
`ifdef SERIAL_ENCODER32_COUNT_EN
    chk("after_count", {26'b0, out_count}, 32'd0);
`endif
  endtask

  typedef struct {
    logic [31:0] mask;
    int          mode;
    int          n_exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int hs;
    logic [31:0] rm;
    n_vec = 0;
    n_err = 0;

    vecs[0] = '{32'h8000_0001, 0, 2};
    vecs[1] = '{32'h0000_0000, 0, 0};
    vecs[2] = '{32'hFFFF_FFFF, 1, 32};
    vecs[3] = '{32'h0000_0001, 0, 1};
    vecs[4] = '{32'h8000_0000, 1, 1};
    vecs[5] = '{32'h0000_00F0, 0, 4};
    vecs[6] = '{32'hAAAA_5555, 2, 16};
    vecs[7] = '{32'hFFFF_FFFF, 0, 32};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_index", {27'b0, out_index}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
`ifdef SERIAL_ENCODER32_COUNT_EN
    chk("rst_count", {26'b0, out_count}, 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk("ready_after_release", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      send_mask(vecs[i].mask, vecs[i].mode, 1'b0, hs);
      chk("handshakes", hs, vecs[i].n_exp);
    end

    // A mask offered during EMIT is ignored, then captured once back in IDLE.
    send_mask(32'h0000_0110, 0, 1'b1, hs);
    chk("hold_handshakes", hs, 32'd2);
    send_mask(32'hFFFF_FFFF, 2, 1'b0, hs);
    chk("held_mask_handshakes", hs, 32'd32);

    // Reset mid-emission aborts and nothing is emitted after release.
    while (!in_ready) tick();
    in_valid = 1'b1;
    in_mask  = 32'h0F00_0000;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("abort_first_index", {27'b0, out_index}, 32'd24);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_index", {27'b0, out_index}, 32'd0);
    chk("abort_last", {31'b0, out_last}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("abort_quiet", {31'b0, out_valid}, 32'd0);
    end
    chk("abort_ready_back", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Randomised masks against the index-list model.
    for (int r = 0; r < 24; r++) begin
      int exp_n;
      rm = $urandom();
      if (r % 3 == 1) rm = rm & $urandom() & $urandom();
      if (r % 7 == 6) rm = 32'h0;
      exp_n = $countones(rm);
      send_mask(rm, $urandom_range(2), 1'b0, hs);
      chk("rand_handshakes", hs, exp_n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
